// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester ports, the RAM request/response
// port and the wipe control/status lines. The slave modport is the arbiter's
// view; the master modport is the view of whatever surrounds it.
interface ram_arbiter_if;
  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_din;
  logic [3:0]  m0_wstrb;
  logic        m0_ready;
  logic [31:0] m0_dout;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_din;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_dout;

  logic        wipe_req;
  logic        wipe_busy;
  logic        wipe_done;

  logic        ram_valid;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_dout;
  logic        ram_ready;

  modport slave (
    input  m0_valid, m0_addr, m0_din, m0_wstrb,
    output m0_ready, m0_dout,
    input  m1_valid, m1_addr, m1_din, m1_wstrb,
    output m1_ready, m1_dout,
    input  wipe_req,
    output wipe_busy, wipe_done,
    output ram_valid, ram_addr, ram_din, ram_wstrb,
    input  ram_dout, ram_ready
  );

  modport master (
    output m0_valid, m0_addr, m0_din, m0_wstrb,
    input  m0_ready, m0_dout,
    output m1_valid, m1_addr, m1_din, m1_wstrb,
    input  m1_ready, m1_dout,
    output wipe_req,
    input  wipe_busy, wipe_done,
    input  ram_valid, ram_addr, ram_din, ram_wstrb,
    output ram_dout, ram_ready
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM, with a
// zeroization engine that walks every word and writes zero. Requests are
// forwarded combinationally; only the FSM state, the wipe word counter and
// the last-grant bit are registered.
module ram_arbiter #(
  parameter int ADDR_BITS     = 10,
  parameter bit WIPE_ON_RESET = 1'b0
) (
  input  logic      clk,
  input  logic      resetn,
  ram_arbiter_if.slave bus
);

  localparam int CNT_BITS = ADDR_BITS - 2;
  localparam logic [CNT_BITS-1:0] CNT_LAST = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WIPE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;  // 1 = m1 served last
  logic                grant_m0, grant_m1;

  // Round-robin pick: a lone requester always wins; on contention the one
  // not served by the last completed transfer wins.
  always_comb begin
    grant_m1 = bus.m1_valid && (!bus.m0_valid || !last_grant_q);
    grant_m0 = bus.m0_valid && !grant_m1;
  end

  // State register; a wipe-on-reset build leaves reset already in WIPE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= WIPE_ON_RESET ? ST_WIPE : ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state, word counter and last-grant bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if ((grant_m0 || grant_m1) && bus.ram_ready) begin
          last_grant_d = grant_m1;
        end
        if (bus.wipe_req) begin
          state_d = ST_WIPE;
          cnt_d   = '0;
        end
      end
      ST_WIPE: begin
        if (bus.ram_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; while resetn is low everything looks like an idle arbiter with
  // no grants, regardless of the registered state.
  always_comb begin
    bus.ram_valid = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_din   = '0;
    bus.ram_wstrb = '0;
    bus.m0_ready  = 1'b0;
    bus.m1_ready  = 1'b0;
    bus.m0_dout   = bus.ram_dout;
    bus.m1_dout   = bus.ram_dout;
    bus.wipe_busy = 1'b0;
    bus.wipe_done = 1'b0;
    if (resetn) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_m0) begin
            bus.ram_valid = 1'b1;
            bus.ram_addr  = bus.m0_addr;
            bus.ram_din   = bus.m0_din;
            bus.ram_wstrb = bus.m0_wstrb;
            bus.m0_ready  = bus.ram_ready;
          end else if (grant_m1) begin
            bus.ram_valid = 1'b1;
            bus.ram_addr  = bus.m1_addr;
            bus.ram_din   = bus.m1_din;
            bus.ram_wstrb = bus.m1_wstrb;
            bus.m1_ready  = bus.ram_ready;
          end
        end
        ST_WIPE: begin
          bus.wipe_busy = 1'b1;
          bus.ram_valid = 1'b1;
          bus.ram_addr  = {{(32-ADDR_BITS){1'b0}}, cnt_q, 2'b00};
          bus.ram_wstrb = 4'b1111;
        end
        ST_DONE: bus.wipe_done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
